// File: rtl/vector_pkg.sv
// Shared constants and types for the vector register bank and execution unit.
package vector_pkg;

   localparam int unsigned VLEN  = 4;
   localparam int unsigned WIDTH = 32;

   typedef enum logic [2:0] {
      VADD = 3'b000,
      VSUB = 3'b001,
      VMUL = 3'b010,
      VAND = 3'b011,
      VOR  = 3'b100,
      VXOR = 3'b101,
      VSLL = 3'b110,
      VSRL = 3'b111
   } vop_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      WRITE = 2'd2
   } vexec_state_t;

endpackage

// File: rtl/vector_lane_alu.sv
// Single combinational lane ALU, time-multiplexed across lanes by the execution unit.
module vector_lane_alu
   import vector_pkg::*;
#(
   parameter int unsigned WIDTH = vector_pkg::WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  vop_t             op,
   output logic [WIDTH-1:0] y
);

   logic [4:0] shamt;
   assign shamt = b[4:0];

   always_comb begin
      y = '0;
      unique case (op)
         VADD: y = a + b;
         VSUB: y = a - b;
         VMUL: y = a * b;
         VAND: y = a & b;
         VOR:  y = a | b;
         VXOR: y = a ^ b;
         VSLL: y = a << shamt;
         VSRL: y = a >> shamt;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/vector_exec_unit.sv
// Multi-cycle vector execution unit: latches two source vectors, computes one lane per cycle,
// then pulses a bank write with the four results.
module vector_exec_unit
   import vector_pkg::*;
#(
   parameter int unsigned WIDTH = vector_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [1:0]       vd_in,
   input  logic [WIDTH-1:0] v11,
   input  logic [WIDTH-1:0] v12,
   input  logic [WIDTH-1:0] v13,
   input  logic [WIDTH-1:0] v14,
   input  logic [WIDTH-1:0] v21,
   input  logic [WIDTH-1:0] v22,
   input  logic [WIDTH-1:0] v23,
   input  logic [WIDTH-1:0] v24,
   output logic             busy,
   output logic             done,
   output logic             write_enable,
   output logic [1:0]       vd,
   output logic [WIDTH-1:0] vw1,
   output logic [WIDTH-1:0] vw2,
   output logic [WIDTH-1:0] vw3,
   output logic [WIDTH-1:0] vw4
);

   vexec_state_t     state_q, state_d;
   logic [1:0]       lane_q, lane_d;
   vop_t             op_q;
   logic [1:0]       dst_q;
   logic [1:0]       vd_q;
   logic [WIDTH-1:0] a_q  [VLEN];
   logic [WIDTH-1:0] b_q  [VLEN];
   logic [WIDTH-1:0] r_q  [VLEN];
   logic [WIDTH-1:0] vw_q [VLEN];
   logic [WIDTH-1:0] alu_y;
   logic             accept;
   logic             last_lane;

   assign accept    = (state_q == IDLE) && start;
   assign last_lane = (state_q == EXEC) && (lane_q == 2'd3);

   vector_lane_alu #(
      .WIDTH (WIDTH)
   ) u_lane_alu (
      .a  (a_q[lane_q]),
      .b  (b_q[lane_q]),
      .op (op_q),
      .y  (alu_y)
   );

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = EXEC;
               lane_d  = 2'd0;
            end
         end
         EXEC: begin
            lane_d = lane_q + 2'd1;
            if (lane_q == 2'd3) state_d = WRITE;
         end
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         lane_q  <= 2'd0;
         op_q    <= VADD;
         dst_q   <= 2'd0;
         vd_q    <= 2'd0;
         for (int i = 0; i < VLEN; i++) begin
            a_q[i]  <= '0;
            b_q[i]  <= '0;
            r_q[i]  <= '0;
            vw_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         if (accept) begin
            op_q   <= vop_t'(op);
            dst_q  <= vd_in;
            a_q[0] <= v11;
            a_q[1] <= v12;
            a_q[2] <= v13;
            a_q[3] <= v14;
            b_q[0] <= v21;
            b_q[1] <= v22;
            b_q[2] <= v23;
            b_q[3] <= v24;
         end
         if (state_q == EXEC) r_q[lane_q] <= alu_y;
         // Output registers load only at the end of EXEC so they hold until the next writeback.
         if (last_lane) begin
            vd_q <= dst_q;
            for (int i = 0; i < VLEN - 1; i++) vw_q[i] <= r_q[i];
            vw_q[VLEN-1] <= alu_y;
         end
      end
   end

   assign busy         = (state_q != IDLE);
   assign done         = (state_q == WRITE);
   assign write_enable = (state_q == WRITE);
   assign vd           = vd_q;
   assign vw1          = vw_q[0];
   assign vw2          = vw_q[1];
   assign vw3          = vw_q[2];
   assign vw4          = vw_q[3];

endmodule

// File: tb/tb_vector_exec_unit.sv
// Directed and randomized bench for vector_exec_unit against an arithmetic reference model.
module tb_vector_exec_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [2:0]   op;
   logic [1:0]   vd_in;
   logic [W-1:0] v11, v12, v13, v14, v21, v22, v23, v24;
   logic         busy, done, write_enable;
   logic [1:0]   vd;
   logic [W-1:0] vw1, vw2, vw3, vw4;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   vector_exec_unit #(
      .WIDTH (W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .op           (op),
      .vd_in        (vd_in),
      .v11          (v11),
      .v12          (v12),
      .v13          (v13),
      .v14          (v14),
      .v21          (v21),
      .v22          (v22),
      .v23          (v23),
      .v24          (v24),
      .busy         (busy),
      .done         (done),
      .write_enable (write_enable),
      .vd           (vd),
      .vw1          (vw1),
      .vw2          (vw2),
      .vw3          (vw3),
      .vw4          (vw4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: each rule written as plain unsigned arithmetic modulo 2^32.
   function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
      longint unsigned x, y, m, p;
      x = longint'(a);
      y = longint'(b);
      m = 64'h1_0000_0000;
      p = 64'd1 << (y % 32);
      case (o)
         3'd0:    return 32'((x + y) % m);
         3'd1:    return 32'((x + m - y) % m);
         3'd2:    return 32'((x * y) % m);
         3'd3:    return a & b;
         3'd4:    return a | b;
         3'd5:    return a ^ b;
         3'd6:    return 32'((x * p) % m);
         default: return 32'(x / p);
      endcase
   endfunction

   function automatic logic [127:0] vw_obs();
      return {vw4, vw3, vw2, vw1};
   endfunction

   task automatic drive_vec(input logic [3:0][31:0] a, input logic [3:0][31:0] b);
      {v14, v13, v12, v11} = a;
      {v24, v23, v22, v21} = b;
   endtask

   task automatic scramble_bank();
      v11 = $urandom; v12 = $urandom; v13 = $urandom; v14 = $urandom;
      v21 = $urandom; v22 = $urandom; v23 = $urandom; v24 = $urandom;
   endtask

   function automatic logic [3:0][31:0] model_vec(input logic [2:0] o,
                                                  input logic [3:0][31:0] a,
                                                  input logic [3:0][31:0] b);
      logic [3:0][31:0] r;
      for (int i = 0; i < 4; i++) r[i] = ref_op(o, a[i], b[i]);
      return r;
   endfunction

   // Issue one op from IDLE and follow it through writeback and the following IDLE cycle.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [1:0] d,
                         input logic [3:0][31:0] a, input logic [3:0][31:0] b,
                         input logic [3:0][31:0] exp, input bit noise);
      int we_cnt;
      we_cnt = 0;
      op = o; vd_in = d; drive_vec(a, b); start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (write_enable) we_cnt++;
         start = 1'b0;
         chk({tag, " busy"}, 128'(busy), 128'(1));
         if (c == 5) begin
            chk({tag, " we"}, 128'(write_enable), 128'(1));
            chk({tag, " done"}, 128'(done), 128'(1));
            chk({tag, " vd"}, 128'(vd), 128'(d));
            chk({tag, " vw"}, vw_obs(), 128'(exp));
         end
         if (noise) begin
            scramble_bank();
            vd_in = 2'($urandom);
            if (c == 2 || c == 5) begin
               start = 1'b1;
               op    = 3'($urandom);
            end
         end
      end
      tick();
      start = 1'b0;
      if (write_enable) we_cnt++;
      chk({tag, " idle busy"}, 128'(busy), 128'(0));
      chk({tag, " idle done"}, 128'(done), 128'(0));
      chk({tag, " we count"}, 128'(we_cnt), 128'(1));
      chk({tag, " vw hold"}, vw_obs(), 128'(exp));
   endtask

   logic [3:0][31:0] ra, rb;
   logic [2:0]       rop;
   logic [1:0]       rvd;
   logic [3:0][31:0] bb_exp [3];
   logic [1:0]       bb_vd  [3];
   int               cnt;

   initial begin
      rst = 1'b1; start = 1'b0; op = 3'd0; vd_in = 2'd0;
      drive_vec('0, '0);
      tick();
      tick();
      chk("reset busy", 128'(busy), 128'(0));
      chk("reset done", 128'(done), 128'(0));
      chk("reset we", 128'(write_enable), 128'(0));
      chk("reset vd", 128'(vd), 128'(0));
      chk("reset vw", vw_obs(), 128'(0));
      rst = 1'b0;

      run_op("add", 3'd0, 2'd2, {32'hFFFFFFFF, 32'd3, 32'd2, 32'd1},
             {32'd1, 32'd30, 32'd20, 32'd10}, {32'd0, 32'd33, 32'd22, 32'd11}, 1'b0);
      run_op("sub", 3'd1, 2'd1, {32'd9, 32'd7, 32'd5, 32'd0},
             {32'd10, 32'd2, 32'd5, 32'd1}, {32'hFFFFFFFF, 32'd5, 32'd0, 32'hFFFFFFFF}, 1'b0);
      run_op("mul", 3'd2, 2'd3, {32'd0, 32'hFFFFFFFF, 32'h10000, 32'd3},
             {32'd9, 32'd2, 32'h10000, 32'd7}, {32'd0, 32'hFFFFFFFE, 32'd0, 32'd21}, 1'b0);
      run_op("srl", 3'd7, 2'd0, {4{32'h80000000}}, {32'd4, 32'd33, 32'd0, 32'd31},
             {32'h08000000, 32'h40000000, 32'h80000000, 32'd1}, 1'b0);
      run_op("sll", 3'd6, 2'd1, {4{32'd1}}, {32'd4, 32'd33, 32'd0, 32'd31},
             {32'h10, 32'd2, 32'd1, 32'h80000000}, 1'b0);
      run_op("isolate", 3'd0, 2'd2, {32'd40, 32'd30, 32'd20, 32'd10},
             {32'd4, 32'd3, 32'd2, 32'd1}, {32'd44, 32'd33, 32'd22, 32'd11}, 1'b1);

      for (int n = 0; n < 16; n++) begin
         rop = 3'($urandom);
         rvd = 2'($urandom);
         for (int i = 0; i < 4; i++) begin
            ra[i] = $urandom;
            rb[i] = (n % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         end
         run_op("rand", rop, rvd, ra, rb, model_vec(rop, ra, rb), n[0]);
      end

      // Abort an XOR with reset at cycle 3.
      for (int i = 0; i < 4; i++) begin ra[i] = $urandom; rb[i] = $urandom; end
      op = 3'd5; vd_in = 2'd3; drive_vec(ra, rb); start = 1'b1;
      cnt = 0;
      for (int c = 1; c <= 3; c++) begin
         tick();
         start = 1'b0;
         if (write_enable) cnt++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort busy", 128'(busy), 128'(0));
      chk("abort vw", vw_obs(), 128'(0));
      chk("abort vd", 128'(vd), 128'(0));
      for (int c = 0; c < 6; c++) begin
         if (write_enable) cnt++;
         tick();
      end
      chk("abort no we", 128'(cnt), 128'(0));
      run_op("after abort", 3'd5, 2'd1, ra, rb, model_vec(3'd5, ra, rb), 1'b0);

      // Back-to-back issue with start held high; operands sampled at cycles 0, 6, 12.
      cnt = 0;
      start = 1'b1;
      for (int c = 0; c < 18; c++) begin
         if (c > 0) begin
            tick();
            if (write_enable) cnt++;
            if (c % 6 == 5) begin
               chk("b2b we", 128'(write_enable), 128'(1));
               chk("b2b vd", 128'(vd), 128'(bb_vd[c / 6]));
               chk("b2b vw", vw_obs(), 128'(bb_exp[c / 6]));
            end else if (c % 6 == 0) begin
               chk("b2b idle", 128'(busy), 128'(0));
            end
         end
         if (c % 6 == 0) begin
            rop = 3'($urandom);
            rvd = 2'($urandom);
            for (int i = 0; i < 4; i++) begin ra[i] = $urandom; rb[i] = $urandom; end
            op = rop; vd_in = rvd; drive_vec(ra, rb);
            bb_exp[c / 6] = model_vec(rop, ra, rb);
            bb_vd[c / 6]  = rvd;
         end else begin
            scramble_bank();
            op = 3'($urandom);
            vd_in = 2'($urandom);
         end
      end
      tick();
      start = 1'b0;
      if (write_enable) cnt++;
      chk("b2b pulses", 128'(cnt), 128'(3));
      chk("b2b end busy", 128'(busy), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vector_exec_unit.md
# vector_exec_unit

Multi-cycle vector execution unit sitting directly downstream of the vector register bank. It consumes two 4-element source vectors read from the bank (`v11..v14`, `v21..v24`) and computes one lane per cycle through a single shared lane ALU. It returns the 4-element result to the bank's write port as a one-cycle `write_enable` pulse with `vw1..vw4` and `vd`. Issue control uses a `start`/`busy`/`done` handshake.

## Interface
Parameters:
- `WIDTH`, 32, element width in bits; all data ports are `WIDTH` wide.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  issue request; sampled only in IDLE.
- `op`  in  3  operation code, sampled with `start`.
- `vd_in`  in  2  destination vector register index, sampled with `start`.
- `v11, v12, v13, v14`  in  WIDTH  source vector A, lanes 0..3, sampled with `start`.
- `v21, v22, v23, v24`  in  WIDTH  source vector B, lanes 0..3, sampled with `start`.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse on the writeback cycle.
- `write_enable`  out  1  bank write strobe; one-cycle pulse, coincident with `done`.
- `vd`  out  2  destination index for the bank write.
- `vw1, vw2, vw3, vw4`  out  WIDTH  result lanes 0..3.

## Operation
- FSM states and transitions:
  - IDLE -> EXEC when `start`=1.
  - EXEC -> WRITE after lane 3 is computed.
  - WRITE -> IDLE unconditionally.
- On acceptance in IDLE:
  - Latch `op`, `vd_in` and all 8 operands into internal registers.
  - Clear the lane counter to 0.
  - After this point, bank outputs may change freely; results depend only on the latched copies.
- EXEC: each cycle, the lane ALU computes `A[lane] op B[lane]` into result register `[lane]`, then the 2-bit lane counter increments. Lane 3 completes EXEC.
- WRITE: `write_enable`=1 and `done`=1, with `vd` and `vw1..vw4` driving the latched destination and the four results.
- Op codes (all arithmetic unsigned, modulo 2^WIDTH, no flags):
  - 000 ADD
  - 001 SUB (A−B)
  - 010 MUL (low WIDTH bits of the product)
  - 011 AND
  - 100 OR
  - 101 XOR
  - 110 SLL: A << B[4:0]
  - 111 SRL: A >> B[4:0], logical
- Output behaviour:
  - `vw1..vw4` and `vd` hold their last written values until the next WRITE.
  - `write_enable` is 0 outside WRITE.
- Handshake boundary cases:
  - `start` outside IDLE is ignored and not queued, including during WRITE.
  - `start` held high continuously re-issues on each return to IDLE.
- Reset:
  - Reset values: state IDLE, lane counter 0, `busy`=0, `done`=0, `write_enable`=0, `vd`=0, `vw1..vw4`=0, internal operand/result registers 0.
  - `rst` asserted in any state aborts the operation. No `write_enable` is produced for the aborted op.
  - `rst` takes priority over `start` in the same cycle.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycles 1–4: EXEC, computing lanes 0, 1, 2, 3 respectively. `busy`=1.
- Cycle 5: WRITE. `busy`=1, `done`=1, `write_enable`=1. The bank captures the result on the rising edge ending cycle 5.
- Cycle 6: IDLE, `busy`=0. The earliest next accepted `start` is cycle 6, giving one op per 6 cycles.
- `busy` is registered and derived from state: it equals (state != IDLE).
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- The lane ALU is combinational within one cycle. The MUL path is the critical path.

## Structure
- Shared package `vector_pkg` holds:
  - `VLEN`=4 and `WIDTH`=32 constants.
  - `vop_t` enum (`VADD`…`VSRL`, 3-bit).
  - `vexec_state_t` enum (IDLE, EXEC, WRITE).
  - The bank uses the same constants.
- One sub-module, `vector_lane_alu`: purely combinational, inputs `a`, `b`, `op`; output `y`. It is instantiated once and time-multiplexed across lanes by the lane counter.
- The top level contains the FSM, lane counter, operand/result registers and output drive.

## Test plan
- ADD with wrap, vd_in=2:
  - Stimulus: A=(1, 2, 3, 0xFFFFFFFF), B=(10, 20, 30, 1).
  - Response: at cycle 5, `write_enable`=1, vd=2, vw=(11, 22, 33, 0). `busy` high cycles 1–5.
- SUB and MUL:
  - SUB: A=(0, 5, 7, 9), B=(1, 5, 2, 10) -> (0xFFFFFFFF, 0, 5, 0xFFFFFFFF).
  - MUL: A=(3, 0x10000, 0xFFFFFFFF, 0), B=(7, 0x10000, 2, 9) -> (21, 0, 0xFFFFFFFE, 0).
- Shifts:
  - SRL: A=0x80000000 all lanes, B=(31, 0, 33, 4) -> (1, 0x80000000, 0x40000000, 0x08000000).
  - SLL: A=1 all lanes, B=(31, 0, 33, 4) -> (0x80000000, 1, 2, 0x10).
- Operand isolation and ignored issue:
  - Stimulus: issue ADD, then change `v11..v24` and pulse `start` with a new op in cycles 2 and 5.
  - Response: the cycle-5 result reflects the original operands only. Exactly one `write_enable` occurs before cycle 6.
- Reset mid-operation:
  - Stimulus: issue XOR, assert `rst` at cycle 3.
  - Response: no `write_enable`, and from cycle 4 `busy`=0 and `vw1..vw4`=0. A fresh issue afterwards completes normally 5 cycles later.
- Back-to-back issue:
  - Stimulus: hold `start` high continuously.
  - Response: `write_enable` pulses at cycles 5, 11, 17, each with correct results and no overlap.
